// File: rtl/sdcard_cmd_ctrl.sv
// SD card CMD-line sequencer: free-running SD clock, 48-bit command frames with CRC7, response capture.
// Optional R1b busy wait on DAT0 is enabled by defining SDCARD_CMD_BUSY_EN.
module sdcard_cmd_ctrl #(
    parameter int CLK_DIV_WIDTH = 8,
    parameter int RESP_TIMEOUT  = 64,
    parameter int GAP_CYCLES    = 8
) (
    input  logic                     io_clk,
    input  logic                     io_nreset,
    input  logic [CLK_DIV_WIDTH-1:0] io_clk_div,
    input  logic                     io_cmd_valid,
    output logic                     io_cmd_ready,
    input  logic [5:0]               io_cmd_index,
    input  logic [31:0]              io_cmd_arg,
    input  logic [1:0]               io_cmd_resp_type,
`ifdef SDCARD_CMD_BUSY_EN
    input  logic                     io_cmd_busy,
    input  logic                     io_sd_dat0,
`endif
    output logic                     io_rsp_valid,
    output logic [1:0]               io_rsp_status,
    output logic [127:0]             io_rsp_data,
    output logic                     io_sd_clk,
    output logic                     io_sd_cmd_out,
    output logic                     io_sd_cmd_oe,
    input  logic                     io_sd_cmd_in,
    output logic                     io_busy
);

    localparam logic [15:0] TO_LAST  = 16'(RESP_TIMEOUT - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_RECV,
`ifdef SDCARD_CMD_BUSY_EN
        S_BUSY,
`endif
        S_GAP
    } state_e;

    state_e                   state_q, state_d;
    logic [CLK_DIV_WIDTH-1:0] div_q, div_d;
    logic                     sdclk_q, sdclk_d;
    logic                     oe_q, oe_d;
    logic                     cout_q, cout_d;
    logic [15:0]              cnt_q, cnt_d;
    logic [39:0]              tx_sh_q, tx_sh_d;
    logic [6:0]               crc_q, crc_d;
    logic [127:0]             rx_sh_q, rx_sh_d;
    logic [1:0]               rtype_q, rtype_d;
    logic [1:0]               stat_q, stat_d;
    logic                     got_q, got_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic [1:0]               rsp_status_q, rsp_status_d;
    logic [127:0]             rsp_data_q, rsp_data_d;
`ifdef SDCARD_CMD_BUSY_EN
    logic                     busy_req_q, busy_req_d;
`endif

    logic        tick, rise, fall;
    logic        long_rsp, crc_chk, crc_on;
    logic [15:0] rx_last;

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = b ^ c[6];
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    // >= rather than == so a shrinking divisor never forces a full counter wrap
    assign tick = (div_q >= io_clk_div);
    assign rise = tick & ~sdclk_q;
    assign fall = tick & sdclk_q;

    assign long_rsp = (rtype_q == 2'd2);
    assign crc_chk  = (rtype_q == 2'd1) || (rtype_q == 2'd2);
    assign rx_last  = long_rsp ? 16'd135 : 16'd47;
    // cnt_q is the position of the incoming bit; CRC covers frame bits 47..8 (short) or 127..8 (long)
    assign crc_on   = long_rsp ? (cnt_q >= 16'd8 && cnt_q <= 16'd127) : (cnt_q <= 16'd39);

    assign io_cmd_ready  = (state_q == S_IDLE) && !rsp_valid_q;
    assign io_busy       = ~io_cmd_ready;
    assign io_rsp_valid  = rsp_valid_q;
    assign io_rsp_status = rsp_status_q;
    assign io_rsp_data   = rsp_data_q;
    assign io_sd_clk     = sdclk_q;
    assign io_sd_cmd_out = cout_q;
    assign io_sd_cmd_oe  = oe_q;

    always_comb begin
        state_d      = state_q;
        div_d        = div_q + 1'b1;
        sdclk_d      = sdclk_q;
        oe_d         = oe_q;
        cout_d       = cout_q;
        cnt_d        = cnt_q;
        tx_sh_d      = tx_sh_q;
        crc_d        = crc_q;
        rx_sh_d      = rx_sh_q;
        rtype_d      = rtype_q;
        stat_d       = stat_q;
        got_d        = got_q;
        rsp_valid_d  = 1'b0;
        rsp_status_d = rsp_status_q;
        rsp_data_d   = rsp_data_q;
`ifdef SDCARD_CMD_BUSY_EN
        busy_req_d   = busy_req_q;
`endif
        if (tick) begin
            div_d   = '0;
            sdclk_d = ~sdclk_q;
        end

        case (state_q)
            S_IDLE: begin
                if (io_cmd_valid && io_cmd_ready) begin
                    state_d = S_SEND;
                    tx_sh_d = {2'b01, io_cmd_index, io_cmd_arg};
                    crc_d   = '0;
                    cnt_d   = '0;
                    rtype_d = io_cmd_resp_type;
                    stat_d  = 2'd0;
                    got_d   = 1'b0;
`ifdef SDCARD_CMD_BUSY_EN
                    busy_req_d = io_cmd_busy;
`endif
                end
            end
            S_SEND: begin
                if (fall) begin
                    if (cnt_q < 16'd40) begin
                        cout_d  = tx_sh_q[39];
                        tx_sh_d = {tx_sh_q[38:0], 1'b0};
                        crc_d   = crc7_step(crc_q, tx_sh_q[39]);
                        oe_d    = 1'b1;
                        cnt_d   = cnt_q + 16'd1;
                    end else if (cnt_q < 16'd47) begin
                        cout_d = crc_q[6];
                        crc_d  = {crc_q[5:0], 1'b0};
                        cnt_d  = cnt_q + 16'd1;
                    end else if (cnt_q == 16'd47) begin
                        cout_d = 1'b1;
                        cnt_d  = cnt_q + 16'd1;
                    end else begin
                        oe_d    = 1'b0;
                        cout_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = (rtype_q == 2'd0) ? S_GAP : S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (rise) begin
                    if (!io_sd_cmd_in) begin
                        state_d = S_RECV;
                        cnt_d   = 16'd1;
                        crc_d   = '0;
                        rx_sh_d = '0;
                    end else if (cnt_q == TO_LAST) begin
                        stat_d  = 2'd1;
                        state_d = S_GAP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            S_RECV: begin
                if (rise) begin
                    rx_sh_d = {rx_sh_q[126:0], io_sd_cmd_in};
                    if (crc_on) crc_d = crc7_step(crc_q, io_sd_cmd_in);
                    if (cnt_q == rx_last) begin
                        got_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = S_GAP;
                        // rx_sh_q[6:0] holds frame bits 7..1 before the end bit shifts in
                        if (!io_sd_cmd_in)
                            stat_d = 2'd3;
                        else if (crc_chk && (crc_q != rx_sh_q[6:0]))
                            stat_d = 2'd2;
                        else
                            stat_d = 2'd0;
`ifdef SDCARD_CMD_BUSY_EN
                        if (busy_req_q && !long_rsp && (stat_d == 2'd0)) state_d = S_BUSY;
`endif
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
`ifdef SDCARD_CMD_BUSY_EN
            S_BUSY: begin
                if (rise && io_sd_dat0) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end
            end
`endif
            S_GAP: begin
                if (rise) begin
                    if (cnt_q == GAP_LAST) begin
                        state_d      = S_IDLE;
                        rsp_valid_d  = 1'b1;
                        rsp_status_d = stat_q;
                        if (got_q)
                            rsp_data_d = long_rsp ? {rx_sh_q[127:1], 1'b0}
                                                  : {90'd0, rx_sh_q[45:8]};
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge io_clk or negedge io_nreset) begin
        if (!io_nreset) begin
            state_q      <= S_IDLE;
            div_q        <= '0;
            sdclk_q      <= 1'b0;
            oe_q         <= 1'b0;
            cout_q       <= 1'b1;
            cnt_q        <= '0;
            tx_sh_q      <= '0;
            crc_q        <= '0;
            rx_sh_q      <= '0;
            rtype_q      <= '0;
            stat_q       <= '0;
            got_q        <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_status_q <= '0;
            rsp_data_q   <= '0;
`ifdef SDCARD_CMD_BUSY_EN
            busy_req_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            sdclk_q      <= sdclk_d;
            oe_q         <= oe_d;
            cout_q       <= cout_d;
            cnt_q        <= cnt_d;
            tx_sh_q      <= tx_sh_d;
            crc_q        <= crc_d;
            rx_sh_q      <= rx_sh_d;
            rtype_q      <= rtype_d;
            stat_q       <= stat_d;
            got_q        <= got_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_status_q <= rsp_status_d;
            rsp_data_q   <= rsp_data_d;
`ifdef SDCARD_CMD_BUSY_EN
            busy_req_q   <= busy_req_d;
`endif
        end
    end

endmodule

// File: tb/tb_sdcard_cmd_ctrl.sv
// Scoreboard bench for sdcard_cmd_ctrl: a card model answers on CMD, a monitor checks every rsp_valid.
module tb_sdcard_cmd_ctrl;

    logic         clk = 1'b0;
    logic         nrst = 1'b0;
    logic [7:0]   clk_div = 8'd1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [5:0]   cmd_index = '0;
    logic [31:0]  cmd_arg = '0;
    logic [1:0]   cmd_rtype = '0;
    logic         rsp_valid;
    logic [1:0]   rsp_status;
    logic [127:0] rsp_data;
    logic         sd_clk, sd_cmd_out, sd_cmd_oe;
    logic         sd_cmd_in = 1'b1;
    logic         busy;
`ifdef SDCARD_CMD_BUSY_EN
    logic         cmd_busy = 1'b0;
    logic         sd_dat0 = 1'b1;
`endif

    sdcard_cmd_ctrl dut (
        .io_clk(clk), .io_nreset(nrst), .io_clk_div(clk_div),
        .io_cmd_valid(cmd_valid), .io_cmd_ready(cmd_ready),
        .io_cmd_index(cmd_index), .io_cmd_arg(cmd_arg), .io_cmd_resp_type(cmd_rtype),
`ifdef SDCARD_CMD_BUSY_EN
        .io_cmd_busy(cmd_busy), .io_sd_dat0(sd_dat0),
`endif
        .io_rsp_valid(rsp_valid), .io_rsp_status(rsp_status), .io_rsp_data(rsp_data),
        .io_sd_clk(sd_clk), .io_sd_cmd_out(sd_cmd_out), .io_sd_cmd_oe(sd_cmd_oe),
        .io_sd_cmd_in(sd_cmd_in), .io_busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [47:0]  frame;
        bit           chk_frame;
        int           len;
        logic [135:0] bits;
        int           busy_clks;
    } card_t;

    typedef struct {
        string        name;
        logic [1:0]   status;
        logic [127:0] data;
        bit           chk_data;
        int           rises;
        bit           rises_dat;
    } exp_t;

    card_t card_q[$];
    exp_t  sb_q[$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] crc7(input logic [127:0] v, input int n);
        logic [6:0] c;
        logic fb;
        c = '0;
        for (int i = n - 1; i >= 0; i--) begin
            fb = v[i] ^ c[6];
            c = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    function automatic logic [47:0] frame48(input logic [1:0] hdr, input logic [5:0] i, input logic [31:0] a);
        logic [39:0] h;
        h = {hdr, i, a};
        return {h, crc7(128'(h), 40), 1'b1};
    endfunction

    function automatic card_t mk_card(input logic [47:0] f, input bit cf, input int len,
                                      input logic [135:0] bits, input int bclk);
        card_t c;
        c.frame = f; c.chk_frame = cf; c.len = len; c.bits = bits; c.busy_clks = bclk;
        return c;
    endfunction

    function automatic exp_t mk_exp(input string nm, input logic [1:0] st, input logic [127:0] d,
                                    input bit cd, input int r, input bit rd);
        exp_t e;
        e.name = nm; e.status = st; e.data = d; e.chk_data = cd; e.rises = r; e.rises_dat = rd;
        return e;
    endfunction

    // SD-clock observers: shifted-out frame, oe-high clocks, rises since oe dropped / since DAT0 released
    logic [47:0] cap = '0;
    int oecnt = 0;
    int rises = 0;
    int dat_rises = 0;
    always @(posedge sd_clk) begin
        cap   <= {cap[46:0], sd_cmd_out};
        oecnt <= sd_cmd_oe ? oecnt + 1 : 0;
        rises <= sd_cmd_oe ? 0 : rises + 1;
`ifdef SDCARD_CMD_BUSY_EN
        dat_rises <= sd_dat0 ? dat_rises + 1 : 0;
`endif
    end

    // Card model: checks the command frame, then answers on falling SD clock edges
    initial begin : card
        card_t c;
        forever begin
            @(negedge sd_cmd_oe);
            if (!nrst) continue;
            if (card_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_cmd frame=0x%0h", cap);
                continue;
            end
            c = card_q.pop_front();
            if (c.chk_frame) chk("cmd_frame", 136'(cap), 136'(c.frame));
            chk("oe_clocks", 136'(oecnt), 136'd48);
            if (c.len > 0) begin
                repeat (2) @(negedge sd_clk);
                for (int i = c.len - 1; i >= 0; i--) begin
                    sd_cmd_in = c.bits[i];
                    @(negedge sd_clk);
                end
                sd_cmd_in = 1'b1;
`ifdef SDCARD_CMD_BUSY_EN
                if (c.busy_clks > 0) begin
                    sd_dat0 = 1'b0;
                    repeat (c.busy_clks) @(negedge sd_clk);
                    sd_dat0 = 1'b1;
                end
`endif
            end
        end
    end

    always @(negedge clk) begin : mon
        exp_t e;
        if (rsp_valid) begin
            if (sb_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_rsp status=%0d", rsp_status);
            end else begin
                e = sb_q.pop_front();
                chk({e.name, "_status"}, 136'(rsp_status), 136'(e.status));
                chk({e.name, "_ready_in_pulse"}, 136'(cmd_ready), 136'd0);
                if (e.chk_data) chk({e.name, "_data"}, 136'(rsp_data), 136'(e.data));
                if (e.rises >= 0)
                    chk({e.name, "_rises"}, 136'(e.rises_dat ? dat_rises : rises), 136'(e.rises));
            end
        end
    end

    task automatic issue(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                         input card_t c, input exp_t e);
        int n;
        card_q.push_back(c);
        sb_q.push_back(e);
        @(negedge clk);
        cmd_index = idx; cmd_arg = arg; cmd_rtype = rt; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 1000) begin @(negedge clk); n++; end
        @(negedge clk);
        cmd_valid = 1'b0;
        chk({e.name, "_ready_busy_after_accept"}, 136'({cmd_ready, busy}), 136'(2'b01));
        n = 0;
        while (!cmd_ready && n < 20000) begin @(negedge clk); n++; end
        if (n >= 20000) begin
            checks++; errors++;
            $display("FAIL %s_done: ready not back after %0d cycles", e.name, n);
        end
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        logic [127:0] cid;
        logic [6:0]   cidcrc;
        int           n;

        repeat (4) @(negedge clk);
        chk("reset_sd_clk", 136'(sd_clk), 136'd0);
        chk("reset_oe", 136'(sd_cmd_oe), 136'd0);
        chk("reset_cmd_out", 136'(sd_cmd_out), 136'd1);
        chk("reset_ready_busy", 136'({cmd_ready, busy}), 136'(2'b10));
        chk("reset_rsp_valid", 136'(rsp_valid), 136'd0);
        chk("reset_rsp", 136'({rsp_status, rsp_data}), 136'd0);
        nrst = 1'b1;
        repeat (4) @(negedge clk);

        issue(6'd0, 32'h0, 2'd0, mk_card(48'h400000000095, 1, 0, '0, 0),
              mk_exp("cmd0", 2'd0, '0, 0, 8, 0));

        issue(6'd8, 32'h1AA, 2'd1, mk_card(48'h48000001AA87, 1, 48, 136'h08000001AA13, 0),
              mk_exp("cmd8_ok", 2'd0, 128'h08000001AA, 1, -1, 0));

        issue(6'd8, 32'h1AA, 2'd1, mk_card(48'h48000001AA87, 1, 48, 136'h08000001AB13, 0),
              mk_exp("cmd8_crc_err", 2'd2, '0, 0, -1, 0));

        issue(6'd8, 32'h1AA, 2'd1, mk_card(48'h48000001AA87, 1, 48, 136'h08000001AA12, 0),
              mk_exp("cmd8_end_err", 2'd3, '0, 0, -1, 0));

        issue(6'd8, 32'h1AA, 2'd1, mk_card(48'h48000001AA87, 1, 48, 136'h08000001AB12, 0),
              mk_exp("cmd8_end_over_crc", 2'd3, '0, 0, -1, 0));

        cid    = 128'h1D4144534431323330000000000001C9;
        cidcrc = crc7(128'(cid[127:8]), 120);
        issue(6'd2, 32'h0, 2'd2,
              mk_card(frame48(2'b01, 6'd2, 32'h0), 1, 136, {8'h3F, cid[127:8], cidcrc, 1'b1}, 0),
              mk_exp("cmd2_r2", 2'd0, {cid[127:8], cidcrc, 1'b0}, 1, -1, 0));

        issue(6'd58, 32'h0, 2'd3, mk_card(48'h7A00000000FD, 1, 48, 136'h3F00FF800001, 0),
              mk_exp("cmd58_r3", 2'd0, 128'h3F00FF8000, 1, -1, 0));

        issue(6'd8, 32'h1AA, 2'd1, mk_card(48'h48000001AA87, 1, 0, '0, 0),
              mk_exp("timeout", 2'd1, 128'h3F00FF8000, 1, 72, 0));

        clk_div = 8'd0;
        issue(6'd0, 32'h0, 2'd0, mk_card(48'h400000000095, 1, 0, '0, 0),
              mk_exp("cmd0_div0", 2'd0, '0, 0, 8, 0));
        clk_div = 8'd1;

`ifdef SDCARD_CMD_BUSY_EN
        cmd_busy = 1'b1;
        issue(6'd7, 32'h12340000, 2'd1,
              mk_card(frame48(2'b01, 6'd7, 32'h12340000), 1, 48,
                      136'(frame48(2'b00, 6'd7, 32'h00000700)), 20),
              mk_exp("cmd7_busy", 2'd0, 128'h0700000700, 1, 9, 1));
        cmd_busy = 1'b0;
`endif

        // Asynchronous reset in the middle of a command frame
        @(negedge clk);
        cmd_index = 6'd17; cmd_arg = 32'hDEADBEEF; cmd_rtype = 2'd1; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!sd_cmd_oe && n < 200) begin @(negedge clk); n++; end
        repeat (40) @(negedge clk);
        #1 nrst = 1'b0;
        #1;
        chk("midsend_reset_oe", 136'(sd_cmd_oe), 136'd0);
        chk("midsend_reset_sd_clk", 136'(sd_clk), 136'd0);
        chk("midsend_reset_cmd_out", 136'(sd_cmd_out), 136'd1);
        chk("midsend_reset_rsp", 136'({rsp_valid, rsp_status, rsp_data}), 136'd0);
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        chk("after_reset_ready", 136'({cmd_ready, busy}), 136'(2'b10));

        n = 0;
        while (sb_q.size() != 0 && n < 2000) begin @(negedge clk); n++; end
        chk("scoreboard_drained", 136'(sb_q.size()), 136'd0);
        chk("card_queue_drained", 136'(card_q.size()), 136'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sdcard_cmd_ctrl.md
Name: sdcard_cmd_ctrl

Overview:
Sequences the SD card CMD line for EndeavourSoc. It generates the SD clock, serialises 48-bit command frames with CRC7, and waits for and deserialises the card response (none, 48-bit or 136-bit). It reports one status per command. It sits between the SD card register interface, which supplies commands, and the io_sdcard_clk/io_sdcard_cmd pads. The pad tristate and pullup live at top level.

Parameters:
CLK_DIV_WIDTH, 8, width of the SD clock half-period divider.
RESP_TIMEOUT, 64, SD clock rising edges to wait for a response start bit (NCR).
GAP_CYCLES, 8, SD clocks of idle after each transaction (NCC/NRC).

Ports:
io_clk  in  1  system clock
io_nreset  in  1  asynchronous reset, active low
io_clk_div  in  CLK_DIV_WIDTH  SD clock half-period = io_clk_div+1 io_clk cycles
io_cmd_valid  in  1  command request
io_cmd_ready  out  1  controller idle; accepts command
io_cmd_index  in  6  command index
io_cmd_arg  in  32  command argument
io_cmd_resp_type  in  2  0 none, 1 short+CRC, 2 long (R2), 3 short, CRC not checked (R3)
io_rsp_valid  out  1  one-cycle pulse; transaction finished
io_rsp_status  out  2  0 ok, 1 timeout, 2 CRC error, 3 end-bit error
io_rsp_data  out  128  response payload, held until next rsp_valid
io_sd_clk  out  1  SD clock
io_sd_cmd_out  out  1  CMD drive value
io_sd_cmd_oe  out  1  CMD drive enable
io_sd_cmd_in  in  1  CMD pad sample
io_busy  out  1  = ~io_cmd_ready

Behaviour:
- Reset (async, any time including mid-frame): state IDLE; io_sd_clk=0, io_sd_cmd_oe=0, io_sd_cmd_out=1, io_cmd_ready=1, io_rsp_valid=0, io_rsp_status=0, io_rsp_data=0, divider=0.
- Clock generator:
  - Divider counts io_clk cycles. When it reaches io_clk_div it reloads 0 and toggles io_sd_clk. The clock is free-running in every state, which covers the 74-clock card init.
  - A toggle 0->1 is a rise event; a toggle 1->0 is a fall event.
  - io_clk_div=0 gives io_clk/2.
  - A changed io_clk_div takes effect at the next reload.
- Handshake:
  - Accept on io_cmd_valid & io_cmd_ready. Index, arg and resp_type are latched.
  - io_cmd_ready drops the next cycle.
- States:
  - IDLE: oe=0. On accept, go to SEND.
  - SEND: at each fall event drive the next bit MSB first. Frame is {0,1,index,arg,crc7,1}, 48 bits. oe=1 from the first fall event until the fall event after bit 0. Then oe=0 and the state goes to WAIT_START, or to GAP if resp_type=0.
  - WAIT_START: sample io_sd_cmd_in at rise events. A 0 goes to RECEIVE. After RESP_TIMEOUT rise events with no 0, status=1 and the state goes to GAP.
  - RECEIVE: shift one bit per rise event; 47 more bits for short, 135 for long. Then check:
    - CRC, unless resp_type 3 or 0.
    - End bit must be 1, else status=3.
    - CRC mismatch gives status=2. End-bit error takes priority over CRC error.
    - Go to GAP.
  - GAP: wait GAP_CYCLES rise events. Then io_rsp_valid=1 for one io_clk cycle and the state returns to IDLE. A new command can be accepted in the cycle after the pulse.
- CRC7:
  - Polynomial x^7+x^3+1, init 0, computed serially.
  - Command: over the 40 bits start..arg.
  - Short response: over frame bits 47..8, compared with bits 7..1.
  - Long response: over frame bits 127..8 (CID/CSD 127..8), compared with bits 7..1.
- io_rsp_data:
  - Short: [37:32]=index field, [31:0]=argument field, [127:38]=0.
  - Long: [127:1]=frame bits 127..1, [0]=0.
  - Timeout: data unchanged.
- io_sd_cmd_in is used only for sampling. No synchroniser is needed because sampling occurs half an SD period after the card drives.

Optional Feature:
SDCARD_CMD_BUSY_EN.
- Defined: adds input ports io_cmd_busy (1, latched with the command, meaning R1b) and io_sd_dat0 (1).
  - After a short response with status 0 and busy set, enter BUSY.
  - BUSY samples io_sd_dat0 at rise events and goes to GAP after the first sample of 1. There is no timeout.
  - io_busy stays 1 throughout.
- Undefined: neither port exists, and the BUSY state is absent.

Test Plan:
- CMD0, arg 0, resp_type 0, io_clk_div=1 -> CMD line carries 0x400000000095 MSB first. Each bit is stable across a rise event. oe is high for exactly 48 SD clocks. rsp_valid arrives after 8 gap clocks with status 0.
- CMD8, arg 0x1AA, resp_type 1; model returns 0x08000001AA13 -> sent frame is 0x48000001AA87; status 0; rsp_data=0x08_000001AA.
- Same as above but the model flips one argument bit of the response -> status 2.
- CMD2, resp_type 2; model sends a valid R2 with CID 0x1D4144534431323330000000000001C9 -> status 0 and the CID bits match.
- resp_type 1, no card response -> status 1 after 64 rise events in WAIT_START; rsp_data unchanged. Then assert io_nreset low mid-SEND -> oe=0 and sd_clk=0 immediately; after release, cmd_ready=1.
- With SDCARD_CMD_BUSY_EN: CMD7, busy=1; model holds dat0 low for 20 SD clocks -> rsp_valid does not pulse until dat0 has returned high and the 8 gap clocks have elapsed.
